sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised-width/depth FIFO; successor to the fixed 8-bit/256-entry pointer-MSB FIFO.
- Adds:
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - overflow/underflow error pulses
  - defined simultaneous read/write behaviour
- Sits between producer/consumer stages in the same clock domain. Storage is held in a separate simple dual-port RAM sub-module.

Parameters:
- DW, 8, data width in bits
- AW, 4, address width; DEPTH = 2**AW entries (power of two only)
- AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_data  in  DW  write data
- rd_en  in  1  read request
- rd_data  out  DW  read data
- rd_valid  out  1  rd_data holds newly popped word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0
  - Hence empty=1, almost_empty=1, full=0, almost_full=0 (for AF_LEVEL>=1).
  - RAM contents are not reset.
- Pointers are AW+1 bits. Address = ptr[AW-1:0]. Wrap from DEPTH-1 to 0 is natural; the MSB toggles on each wrap.
- full = (addr bits equal && MSBs differ). empty = (pointers equal). Both must agree with count at all times (assertion).
- Accept rules, evaluated on the rising edge using registered state:
  - rd_ok = rd_en && !empty
  - wr_ok = wr_en && (!full || rd_ok)
- Write: on wr_ok, RAM[wr_ptr] <= wr_data and wr_ptr increments.
- Read: on rd_ok, rd_data <= RAM[rd_ptr], rd_ptr increments, rd_valid=1 next cycle.
  - Read latency is 1 cycle.
  - rd_data holds its last value when no read occurs.
- count next value:
  - +1 if wr_ok only
  - -1 if rd_ok only
  - unchanged if both or neither
- Simultaneous read+write:
  - When empty: write accepted, read rejected (underflow pulses). The written word is not bypassed.
  - When full: both accepted; count stays DEPTH; no overflow.
- overflow = registered (wr_en && !wr_ok); underflow = registered (rd_en && !rd_ok). Each is a one-cycle pulse per rejected request. Rejected requests change no state.
- All status flags are decoded from registered count/pointers only; there is no combinational path from any input to any output.
- Reset asserted mid-operation: all state clears immediately. The first accepted write after reset release is read back first.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - rd_data continuously presents the head entry while !empty.
  - rd_en acknowledges/pops it.
  - rd_valid = !empty (combinationally from registered state).
  - A word written into an empty FIFO appears on rd_data 1 cycle after the write edge.
  - Read latency is 0.
- Not defined: registered 1-cycle read latency as above.
- Accept rules, flags, count and error pulses are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - function clog2
  - localparam-style helper for DEPTH from AW
  - typedef for the status flag bundle (full, empty, almost_full, almost_empty)
- One sub-module: fifo_sdp_ram (parametrised DW/AW; one write port, one read port, both on clk).
  - Registered read in standard mode; asynchronous read used in FWFT mode.

Test Plan:
1. Reset, then push 16 words 0x00..0x0F with no reads -> count steps 1..16; almost_full at count 14; full=1 after 16th; 17th write (0xAA) -> overflow pulse 1 cycle, count stays 16.
2. From full, pop 16 -> rd_data 0x00..0x0F in order, each 1 cycle after rd_en; almost_empty at count 2; empty after last; extra rd_en -> underflow pulse, rd_valid=0.
3. When full, wr_en=rd_en=1 for 5 cycles with data 0x10..0x14 -> no overflow, count=16 throughout. Then drain -> 0x05..0x0F, then 0x10..0x14.
4. When empty, wr_en=rd_en=1 with 0x55 -> underflow pulse, count=1. Next cycle rd_en -> rd_data=0x55.
5. Wrap: 40 cycles of one write and one delayed read -> data intact across 2+ pointer wraps; full/empty always match count (assertion).
6. Reset asserted with count=9 mid-burst -> all outputs at reset values immediately. After release, write 0x3C and read -> 0x3C. With SYNC_FIFO_FWFT_EN, 0x3C is on rd_data with rd_valid=1 before rd_en is asserted.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers and types for the parametrised synchronous FIFO.
//   clog2       : ceiling log2 of a positive integer (elaboration-time helper)
//   depth_of    : number of entries addressed by an AW-bit address
//   fifo_flags_t: bundle of the four decoded status flags
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    // Smallest r such that 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    // Entry count for a power-of-two FIFO with AW address bits.
    function automatic int depth_of(input int aw);
        return 32'sd1 <<< aw;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_param_ram.sv
// -----------------------------------------------------------------------------
// fifo_sdp_ram
// Simple dual-port storage for sync_fifo_param: one write port, one read port,
// both on clk. Contents are never reset.
// Build option SYNC_FIFO_FWFT_EN:
//   undefined : registered read (rdata updates on the edge where re=1, holds
//               otherwise, clears on reset)
//   defined   : asynchronous read (rdata follows raddr), no reset/re ports
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset of the read register (std mode)
//   re           read enable (std mode)
//   we/waddr/wdata  write port
//   raddr        read address
//   rdata        read data
// -----------------------------------------------------------------------------
module fifo_sdp_ram
    import sync_fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic          reset,
    input  logic          re,
`endif
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = depth_of(AW);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port; storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem_r[raddr];
`else
    logic [DW-1:0] rdata_r;

    // Registered read port; on a same-address write it returns the old word,
    // which is what the FIFO needs when it pops and pushes while full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with parametrised width/depth, occupancy count,
// programmable almost-full/almost-empty levels and overflow/underflow pulses.
// Build option SYNC_FIFO_FWFT_EN selects first-word fall-through (read latency
// 0, rd_valid = !empty); otherwise rd_data is registered with 1-cycle latency.
// Ports:
//   clk, reset        clock (rising) / asynchronous active-low reset
//   wr_en, wr_data    write request and data
//   rd_en             read request
//   rd_data, rd_valid read data and its qualifier
//   full, empty, almost_full, almost_empty  status decoded from registered state
//   count             occupancy 0..DEPTH
//   overflow/underflow one-cycle pulse per rejected write/read
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] ONE_C    = (AW+1)'(32'd1);
    localparam logic [AW:0] AF_LVL_C = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL_C = (AW+1)'(AE_LEVEL);

    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;
    logic          underflow_r;
    logic          rd_ok_s;
    logic          wr_ok_s;
    logic [DW-1:0] ram_rdata_s;
    fifo_flags_t   flags_s;

    // Status flags and accept decisions, from registered pointers/count only.
    always_comb begin
        flags_s.empty        = (wr_ptr_r == rd_ptr_r);
        flags_s.full         = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                               (wr_ptr_r[AW] != rd_ptr_r[AW]);
        flags_s.almost_full  = (count_r >= AF_LVL_C);
        flags_s.almost_empty = (count_r <= AE_LVL_C);
        rd_ok_s              = rd_en && !flags_s.empty;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
        wr_ok_s              = wr_en && (!flags_s.full || rd_ok_s);
    end

    // Pointers, occupancy and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            overflow_r  <= wr_en && !wr_ok_s;
            underflow_r <= rd_en && !rd_ok_s;
        end
    end

    fifo_sdp_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .reset (reset),
        .re    (rd_ok_s),
`endif
        .we    (wr_ok_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (ram_rdata_s)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown whenever present; forced to zero when empty so the
    // output is defined after reset even though the RAM is not.
    assign rd_data  = flags_s.empty ? '0 : ram_rdata_s;
    assign rd_valid = !flags_s.empty;
`else
    logic rd_valid_r;

    // rd_valid marks the cycle after an accepted pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s;
        end
    end

    assign rd_data  = ram_rdata_s;
    assign rd_valid = rd_valid_r;
`endif

    assign full         = flags_s.full;
    assign empty        = flags_s.empty;
    assign almost_full  = flags_s.almost_full;
    assign almost_empty = flags_s.almost_empty;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Scoreboard bench for sync_fifo_param (DW=8, AW=4, AF=14, AE=2). The driver
// applies inputs on the falling edge, steps a queue-based model of the FIFO
// and pushes the expected post-edge outputs; a monitor samples 1 time unit
// after each rising edge and pops/compares.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    typedef struct {
        int       cnt;
        bit       ovf;
        bit       unf;
        bit       rvalid;
        bit [7:0] data;
    } exp_t;

    exp_t     exp_q[$];
    bit [7:0] model_q[$];
    int       n_checks;
    int       n_fail;

    sync_fifo_param #(
        .DW       (DW),
        .AW       (AW),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and record what the FIFO must show after the edge.
    task automatic model_step(input bit we, input bit re, input bit [7:0] d);
        exp_t e;
        bit   rok;
        bit   wok;
        wr_en   = we;
        rd_en   = re;
        wr_data = d;
        rok = re && (model_q.size() > 0);
        wok = we && ((model_q.size() < DEPTH) || rok);
        e.ovf  = we && !wok;
        e.unf  = re && !rok;
        e.data = 8'h00;
        if (rok) e.data = model_q.pop_front();
        if (wok) model_q.push_back(d);
        e.cnt = model_q.size();
`ifdef SYNC_FIFO_FWFT_EN
        e.rvalid = (model_q.size() > 0);
        e.data   = (model_q.size() > 0) ? model_q[0] : 8'h00;
`else
        e.rvalid = rok;
`endif
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit we, input bit re, input bit [7:0] d);
        @(negedge clk);
        model_step(we, re, d);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        model_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_step(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compare every post-edge output against the scoreboard entry.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (reset === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underrun: got no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("count", 32'(count), 32'(e.cnt));
                chk("full", 32'(full), 32'(e.cnt == DEPTH));
                chk("empty", 32'(empty), 32'(e.cnt == 0));
                chk("almost_full", 32'(almost_full), 32'(e.cnt >= AF));
                chk("almost_empty", 32'(almost_empty), 32'(e.cnt <= AE));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("underflow", 32'(underflow), 32'(e.unf));
                chk("rd_valid", 32'(rd_valid), 32'(e.rvalid));
                if (e.rvalid) begin
                    chk("rd_data", 32'(rd_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = 8'h00;
        do_reset();

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i));
        cycle(1'b1, 1'b0, 8'hAA);
        cycle(1'b0, 1'b0, 8'h00);

        // Drain in order, then one rejected read.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Simultaneous read/write while full.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Simultaneous read/write while empty: write only, no bypass.
        cycle(1'b1, 1'b1, 8'h55);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Pointer wrap with a read trailing the writes by two cycles.
        for (int i = 0; i < 40; i++) cycle(1'b1, (i >= 2), 8'($urandom));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);

        // Reset in the middle of a burst at count 9.
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'($urandom));
        do_reset();
        cycle(1'b1, 1'b0, 8'h3C);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Random traffic in phases biased towards filling and draining.
        for (int p = 0; p < 4; p++) begin
            int wpct;
            int rpct;
            wpct = (p % 2 == 0) ? 75 : 30;
            rpct = (p % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 100; i++) begin
                cycle(($urandom_range(0, 99) < wpct), ($urandom_range(0, 99) < rpct), 8'($urandom));
            end
        end
        cycle(1'b0, 1'b0, 8'h00);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
